regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU / load-FPU result sources and the
// register-file write port.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [5:0]  alu_addr;
  logic [63:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [5:0]  mem_addr;
  logic [63:0] mem_data;
  logic        write_enable;
  logic [5:0]  write_addr;
  logic [63:0] write_data;
  logic        busy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  write_enable, write_addr, write_data, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output write_enable, write_addr, write_data, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: two per-source FIFOs (ALU, load/FPU)
// merged round-robin onto a single registered write port.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH   = 2,
  parameter bit          DROP_X0 = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 70;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [EW-1:0] q_mem    [2][DEPTH];
  logic [PW-1:0] wr_ptr   [2];
  logic [PW-1:0] rd_ptr   [2];
  logic [CW-1:0] count    [2];
  logic [EW-1:0] in_entry [2];
  logic [EW-1:0] head     [2];
  logic [1:0]    in_valid;
  logic [1:0]    q_ready;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nonempty;

  src_e        last_grant;
  src_e        grant_src;
  logic        grant_valid;
  logic        we_q;
  logic [5:0]  wa_q;
  logic [63:0] wd_q;

  // Per-queue status and accept decode; x0 writes complete the handshake but are not stored.
  always_comb begin
    in_valid    = {bus.mem_valid, bus.alu_valid};
    in_entry[0] = {bus.alu_addr, bus.alu_data};
    in_entry[1] = {bus.mem_addr, bus.mem_data};
    q_ready     = '0;
    nonempty    = '0;
    push        = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      q_ready[i]  = count[i] < FULL;
      nonempty[i] = count[i] != '0;
      push[i]     = in_valid[i] && q_ready[i] &&
                    !(DROP_X0 && (in_entry[i][EW-1 -: 6] == 6'd0));
      head[i]     = q_mem[i][rd_ptr[i]];
    end
  end

  // Round-robin grant: a lone non-empty queue wins, otherwise the one not granted last.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    pop         = '0;
    if (nonempty[0] && nonempty[1]) begin
      grant_valid = 1'b1;
      grant_src   = (last_grant == SRC_MEM) ? SRC_ALU : SRC_MEM;
    end else if (nonempty[0]) begin
      grant_valid = 1'b1;
      grant_src   = SRC_ALU;
    end else if (nonempty[1]) begin
      grant_valid = 1'b1;
      grant_src   = SRC_MEM;
    end
    if (grant_valid) pop[grant_src] = 1'b1;
  end

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Queue storage, left unreset since occupancy alone determines validity.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (!rst && push[i]) q_mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

  // Registered write port; address/data hold when no grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      last_grant <= SRC_MEM;
    end else begin
      we_q <= grant_valid;
      if (grant_valid) begin
        {wa_q, wd_q} <= head[grant_src];
        last_grant   <= grant_src;
      end
    end
  end

  assign bus.alu_ready    = q_ready[0];
  assign bus.mem_ready    = q_ready[1];
  assign bus.write_enable = we_q;
  assign bus.write_addr   = wa_q;
  assign bus.write_data   = wd_q;
  assign bus.busy         = (|nonempty) || we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter_if bus0 ();

  regfile_wb_arbiter #(.DEPTH(2), .DROP_X0(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_wb_arbiter #(.DEPTH(2), .DROP_X0(1'b0)) u_dut_nodrop (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [5:0]  aa;
    logic [63:0] ad;
    logic        mv;
    logic [5:0]  ma;
    logic [63:0] md;
    logic        we;
    logic [5:0]  wa;
    logic [63:0] wd;
    logic        ar;
    logic        mr;
    logic        busy;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic r, input logic av, input logic [5:0] aa, input logic [63:0] ad,
    input logic mv, input logic [5:0] ma, input logic [63:0] md,
    input logic we, input logic [5:0] wa, input logic [63:0] wd,
    input logic ar, input logic mr, input logic busy);
    vec_t v;
    v.rst = r;  v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv;  v.ma = ma; v.md = md;
    v.we = we;  v.wa = wa; v.wd = wd;
    v.ar = ar;  v.mr = mr; v.busy = busy;
    return v;
  endfunction

  // Write monitor for the multi-source sequence
  bit          mon_en = 1'b0;
  bit          mem_full_seen = 1'b0;
  int          cyc = 0;
  logic [5:0]  log_addr [$];
  logic [63:0] log_data [$];
  int          log_cyc  [$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_en) begin
      if (bus.write_enable) begin
        log_addr.push_back(bus.write_addr);
        log_data.push_back(bus.write_data);
        log_cyc.push_back(cyc);
      end
      if (!bus.mem_ready) mem_full_seen = 1'b1;
    end
  end

  // Hold valid until the handshake completes; ready is registered so it is sampled at negedge.
  task automatic send(input bit src_mem, input logic [5:0] addr, input logic [63:0] data);
    bit ok = 1'b0;
    bit rdy;
    if (src_mem) begin
      bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_data = data;
    end else begin
      bus.alu_valid = 1'b1; bus.alu_addr = addr; bus.alu_data = data;
    end
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      rdy = src_mem ? bus.mem_ready : bus.alu_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    check(src_mem ? "bp_mem_accept" : "bp_alu_accept", 128'(ok), 128'(1'b1));
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus0.alu_valid = 1'b0; bus0.alu_addr = '0; bus0.alu_data = '0;
    bus0.mem_valid = 1'b0; bus0.mem_addr = '0; bus0.mem_data = '0;

    //             rst av aa  ad        mv ma  md         we wa  wd        ar mr busy
    vecs[0]  = mk(1, 0, 0,  64'h0,    0, 0,  64'h0,     0, 0,  64'h0,    1, 1, 0);
    vecs[1]  = mk(0, 1, 5,  64'hDEAD, 0, 0,  64'h0,     0, 0,  64'h0,    1, 1, 1);
    vecs[2]  = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     1, 5,  64'hDEAD, 1, 1, 1);
    vecs[3]  = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     0, 5,  64'hDEAD, 1, 1, 0);
    vecs[4]  = mk(1, 0, 0,  64'h0,    0, 0,  64'h0,     0, 0,  64'h0,    1, 1, 0);
    vecs[5]  = mk(0, 1, 3,  64'h11,   1, 40, 64'h22,    0, 0,  64'h0,    1, 1, 1);
    vecs[6]  = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     1, 3,  64'h11,   1, 1, 1);
    vecs[7]  = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     1, 40, 64'h22,   1, 1, 1);
    vecs[8]  = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     0, 40, 64'h22,   1, 1, 0);
    vecs[9]  = mk(0, 1, 0,  64'hFF,   0, 0,  64'h0,     0, 40, 64'h22,   1, 1, 0);
    vecs[10] = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     0, 40, 64'h22,   1, 1, 0);
    vecs[11] = mk(0, 0, 0,  64'h0,    1, 32, 64'h77,    0, 40, 64'h22,   1, 1, 1);
    vecs[12] = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     1, 32, 64'h77,   1, 1, 1);
    vecs[13] = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     0, 32, 64'h77,   1, 1, 0);
    vecs[14] = mk(0, 1, 7,  64'hA1,   1, 8,  64'hB1,    0, 32, 64'h77,   1, 1, 1);
    vecs[15] = mk(0, 1, 9,  64'hA2,   0, 0,  64'h0,     1, 7,  64'hA1,   1, 1, 1);
    vecs[16] = mk(1, 1, 10, 64'hA3,   1, 11, 64'hB3,    0, 0,  64'h0,    1, 1, 0);
    vecs[17] = mk(0, 0, 0,  64'h0,    0, 0,  64'h0,     0, 0,  64'h0,    1, 1, 0);

    for (int i = 0; i < NV; i++) begin
      rst           = vecs[i].rst;
      bus.alu_valid = vecs[i].av; bus.alu_addr = vecs[i].aa; bus.alu_data = vecs[i].ad;
      bus.mem_valid = vecs[i].mv; bus.mem_addr = vecs[i].ma; bus.mem_data = vecs[i].md;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            128'({bus.write_enable, bus.write_addr, bus.write_data,
                  bus.alu_ready, bus.mem_ready, bus.busy}),
            128'({vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ar, vecs[i].mr, vecs[i].busy}));
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;

    // Backpressure: both sources stream 4 requests each after a reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    fork
      begin
        for (int j = 0; j < 4; j++) send(1'b0, 6'(10 + j), 64'h200 + 64'(j));
        bus.alu_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) send(1'b1, 6'(50 + j), 64'h100 + 64'(j));
        bus.mem_valid = 1'b0;
      end
    join
    repeat (6) @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("bp_mem_ready_low", 128'(mem_full_seen), 128'(1'b1));
    check("bp_write_count", 128'(log_addr.size()), 128'(8));
    if (log_addr.size() == 8) begin
      int na = 0;
      int nm = 0;
      for (int j = 0; j < 8; j++) begin
        if (log_addr[j] >= 6'd50) begin
          check("bp_mem_order", 128'({log_addr[j], log_data[j]}),
                128'({6'(50 + nm), 64'h100 + 64'(nm)}));
          nm++;
        end else begin
          check("bp_alu_order", 128'({log_addr[j], log_data[j]}),
                128'({6'(10 + na), 64'h200 + 64'(na)}));
          na++;
        end
      end
      check("bp_back_to_back", 128'(log_cyc[7] - log_cyc[0]), 128'(7));
    end

    // Pointer wrap: 10 consecutive ALU writes, each one cycle after acceptance.
    for (int i = 0; i < 11; i++) begin
      bus.alu_valid = (i < 10);
      bus.alu_addr  = 6'(i + 1);
      bus.alu_data  = 64'h1000 + 64'(i);
      @(posedge clk);
      #1;
      if (i >= 1)
        check($sformatf("wrap%0d", i),
              128'({bus.write_enable, bus.write_addr, bus.write_data}),
              128'({1'b1, 6'(i), 64'h1000 + 64'(i - 1)}));
    end
    bus.alu_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_idle", 128'({bus.write_enable, bus.busy}), 128'(2'b00));

    // x0 is writable when dropping is disabled.
    bus0.alu_valid = 1'b1; bus0.alu_addr = 6'd0; bus0.alu_data = 64'hFF;
    @(posedge clk); #1;
    bus0.alu_valid = 1'b0;
    check("nodrop_queued", 128'({bus0.write_enable, bus0.busy}), 128'(2'b01));
    @(posedge clk); #1;
    check("nodrop_write", 128'({bus0.write_enable, bus0.write_addr, bus0.write_data}),
          128'({1'b1, 6'd0, 64'hFF}));
    @(posedge clk); #1;
    check("nodrop_idle", 128'(bus0.write_enable), 128'(1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
